// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - command-driven load/run/dump sequencer for cpu_top
module cpu_run_ctrl #(
  parameter int             IMEM_DEPTH = 1024,
  parameter int             RUN_CNT_W  = 16,
  parameter int             NUM_REGS   = 15,
  parameter logic [3:0]     STAT_AOK   = 4'h1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 cmd_load,
  input  logic [10:0]          load_len,
  input  logic                 cmd_run,
  input  logic [RUN_CNT_W-1:0] run_cycles,
  input  logic                 cmd_dump,
  input  logic                 host_valid,
  input  logic [7:0]           host_data,
  output logic                 host_ready,
  output logic                 imem_wr_en,
  output logic [63:0]          imem_wr_addr,
  output logic [7:0]           imem_wr_data,
  output logic                 valid,
  output logic                 debug,
  output logic [3:0]           reg_addr_debug,
  output logic [7:0]           dmem_addr_debug,
  input  logic [63:0]          reg_val_debug,
  input  logic [3:0]           status,
  output logic                 dump_valid,
  output logic [3:0]           dump_idx,
  output logic [63:0]          dump_data,
  input  logic                 dump_ready,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           run_status,
  output logic [RUN_CNT_W-1:0] run_count
);

  localparam int LEN_W = 11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_FIN} state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                 host_ready_q, host_ready_d;
  logic                 imem_wr_en_q, imem_wr_en_d;
  logic [LEN_W-1:0]     imem_wr_addr_q, imem_wr_addr_d;
  logic [7:0]           imem_wr_data_q, imem_wr_data_d;
  logic [RUN_CNT_W-1:0] run_lim_q, run_lim_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic                 valid_q, valid_d;
  logic                 debug_q, debug_d;
  logic [3:0]           reg_addr_q, reg_addr_d;
  logic                 dump_valid_q, dump_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           run_status_q, run_status_d;
  logic [RUN_CNT_W-1:0] run_count_q, run_count_d;

  logic [LEN_W-1:0]     load_len_sat;
  logic [LEN_W-1:0]     byte_cnt_inc;
  logic [RUN_CNT_W-1:0] run_cnt_inc;

  assign load_len_sat = (load_len > LEN_W'(IMEM_DEPTH)) ? LEN_W'(IMEM_DEPTH) : load_len;
  assign byte_cnt_inc = byte_cnt_q + LEN_W'(1);
  assign run_cnt_inc  = run_cnt_q + RUN_CNT_W'(1);

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    byte_cnt_d     = byte_cnt_q;
    host_ready_d   = host_ready_q;
    imem_wr_en_d   = 1'b0;
    imem_wr_addr_d = imem_wr_addr_q;
    imem_wr_data_d = imem_wr_data_q;
    run_lim_d      = run_lim_q;
    run_cnt_d      = run_cnt_q;
    valid_d        = valid_q;
    debug_d        = debug_q;
    reg_addr_d     = reg_addr_q;
    dump_valid_d   = dump_valid_q;
    run_status_d   = run_status_q;
    run_count_d    = run_count_q;
    done_d         = (state_q == S_FIN);

    case (state_q)
      S_IDLE: begin
        if (cmd_load) begin
          len_d        = load_len_sat;
          byte_cnt_d   = '0;
          host_ready_d = (load_len_sat != '0);
          state_d      = S_LOAD;
        end else if (cmd_run) begin
          run_lim_d = run_cycles;
          run_cnt_d = '0;
          state_d   = S_RUN;
        end else if (cmd_dump) begin
          reg_addr_d   = '0;
          debug_d      = 1'b1;
          dump_valid_d = 1'b1;
          state_d      = S_DUMP;
        end
      end
      S_LOAD: begin
        // host_ready low here only happens for a zero-length load
        if (!host_ready_q) begin
          state_d = S_FIN;
        end else if (host_valid) begin
          imem_wr_en_d   = 1'b1;
          imem_wr_addr_d = byte_cnt_q;
          imem_wr_data_d = host_data;
          byte_cnt_d     = byte_cnt_inc;
          if (byte_cnt_inc == len_q) begin
            host_ready_d = 1'b0;
            state_d      = S_FIN;
          end
        end
      end
      S_RUN: begin
        if (!valid_q) begin
          // entry cycle: either raise valid or finish straight away for a zero budget
          if (run_lim_q == '0) begin
            run_status_d = status;
            run_count_d  = '0;
            state_d      = S_FIN;
          end else begin
            valid_d = 1'b1;
          end
        end else if ((run_cnt_inc == run_lim_q) || (status != STAT_AOK)) begin
          valid_d      = 1'b0;
          run_status_d = status;
          run_count_d  = run_cnt_inc;
          state_d      = S_FIN;
        end else begin
          run_cnt_d = run_cnt_inc;
        end
      end
      S_DUMP: begin
        if (dump_ready) begin
          if (reg_addr_q == 4'(NUM_REGS - 1)) begin
            debug_d      = 1'b0;
            dump_valid_d = 1'b0;
            reg_addr_d   = '0;
            state_d      = S_FIN;
          end else begin
            reg_addr_d = reg_addr_q + 4'd1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All sequencer state and registered outputs; reset aborts any operation at once
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      byte_cnt_q     <= '0;
      host_ready_q   <= 1'b0;
      imem_wr_en_q   <= 1'b0;
      imem_wr_addr_q <= '0;
      imem_wr_data_q <= '0;
      run_lim_q      <= '0;
      run_cnt_q      <= '0;
      valid_q        <= 1'b0;
      debug_q        <= 1'b0;
      reg_addr_q     <= '0;
      dump_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      run_status_q   <= '0;
      run_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      byte_cnt_q     <= byte_cnt_d;
      host_ready_q   <= host_ready_d;
      imem_wr_en_q   <= imem_wr_en_d;
      imem_wr_addr_q <= imem_wr_addr_d;
      imem_wr_data_q <= imem_wr_data_d;
      run_lim_q      <= run_lim_d;
      run_cnt_q      <= run_cnt_d;
      valid_q        <= valid_d;
      debug_q        <= debug_d;
      reg_addr_q     <= reg_addr_d;
      dump_valid_q   <= dump_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      run_status_q   <= run_status_d;
      run_count_q    <= run_count_d;
    end
  end

  assign host_ready      = host_ready_q;
  assign imem_wr_en      = imem_wr_en_q;
  assign imem_wr_addr    = {{(64 - LEN_W){1'b0}}, imem_wr_addr_q};
  assign imem_wr_data    = imem_wr_data_q;
  assign valid           = valid_q;
  assign debug           = debug_q;
  assign reg_addr_debug  = reg_addr_q;
  assign dmem_addr_debug = '0;
  assign dump_valid      = dump_valid_q;
  assign dump_idx        = reg_addr_q;
  // reg_val_debug follows reg_addr_debug, so the word stays put while the index is held
  assign dump_data       = dump_valid_q ? reg_val_debug : '0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign run_status      = run_status_q;
  assign run_count       = run_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        cmd_load, cmd_run, cmd_dump;
  logic [10:0] load_len;
  logic [15:0] run_cycles;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready, imem_wr_en;
  logic [63:0] imem_wr_addr;
  logic [7:0]  imem_wr_data;
  logic        valid, debug;
  logic [3:0]  reg_addr_debug;
  logic [7:0]  dmem_addr_debug;
  logic [63:0] reg_val_debug;
  logic [3:0]  status;
  logic        dump_valid;
  logic [3:0]  dump_idx;
  logic [63:0] dump_data;
  logic        dump_ready;
  logic        busy, done;
  logic [3:0]  run_status;
  logic [15:0] run_count;

  cpu_run_ctrl dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .cmd_load(cmd_load), .load_len(load_len),
    .cmd_run(cmd_run), .run_cycles(run_cycles), .cmd_dump(cmd_dump),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .valid(valid), .debug(debug), .reg_addr_debug(reg_addr_debug),
    .dmem_addr_debug(dmem_addr_debug), .reg_val_debug(reg_val_debug), .status(status),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_ready(dump_ready), .busy(busy), .done(done), .run_status(run_status),
    .run_count(run_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [63:0] addr; logic [7:0] data; } wr_exp_t;
  typedef struct { logic [3:0] idx; logic [63:0] data; } dump_exp_t;
  typedef struct { int cnt; logic [3:0] st; int base; } run_exp_t;

  wr_exp_t   exp_wr_q[$];
  dump_exp_t exp_dump_q[$];
  run_exp_t  exp_run_q[$];

  logic [63:0] reg_model [16];
  logic [7:0]  pat [4];
  assign reg_val_debug = reg_model[reg_addr_debug];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, last_wr_cyc = 0, wr_count = 0, done_cnt = 0;
  int valid_cycles = 0, debug_cycles = 0, cur_op = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare DUT output events against the expectation queues
  always @(negedge sys_clk) begin
    if (rst_n) begin
      cyc <= cyc + 1;
      check_eq("valid_debug_excl", {63'd0, valid & debug}, 64'd0);
      if (valid) valid_cycles <= valid_cycles + 1;
      if (debug) debug_cycles <= debug_cycles + 1;
      if (imem_wr_en) begin
        wr_count    <= wr_count + 1;
        last_wr_cyc <= cyc;
        check_eq("wr_pending", {63'd0, exp_wr_q.size() > 0}, 64'd1);
        if (exp_wr_q.size() > 0) begin
          check_eq("wr_addr", imem_wr_addr, exp_wr_q[0].addr);
          check_eq("wr_data", {56'd0, imem_wr_data}, {56'd0, exp_wr_q[0].data});
          void'(exp_wr_q.pop_front());
        end
      end
      if (dump_valid) begin
        check_eq("dump_debug", {63'd0, debug}, 64'd1);
        check_eq("dump_pending", {63'd0, exp_dump_q.size() > 0}, 64'd1);
        if (exp_dump_q.size() > 0) begin
          check_eq("dump_idx", {60'd0, dump_idx}, {60'd0, exp_dump_q[0].idx});
          check_eq("dump_reg_addr", {60'd0, reg_addr_debug}, {60'd0, exp_dump_q[0].idx});
          check_eq("dump_data", dump_data, exp_dump_q[0].data);
          if (dump_ready) void'(exp_dump_q.pop_front());
        end
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        check_eq("done_wr_drained", exp_wr_q.size(), 64'd0);
        check_eq("done_dump_drained", exp_dump_q.size(), 64'd0);
        check_eq("done_busy_low", {63'd0, busy}, 64'd0);
        if (cur_op == 1) check_eq("done_latency", cyc - last_wr_cyc, 64'd1);
        if (exp_run_q.size() > 0) begin
          check_eq("run_count", {48'd0, run_count}, exp_run_q[0].cnt);
          check_eq("run_status", {60'd0, run_status}, {60'd0, exp_run_q[0].st});
          check_eq("run_valid_cycles", valid_cycles - exp_run_q[0].base, exp_run_q[0].cnt);
          void'(exp_run_q.pop_front());
        end
      end
    end
  end

  task automatic outs_zero(input string pre);
    check_eq({pre, "_ctl"}, {57'd0, host_ready, imem_wr_en, valid, debug, busy, done, dump_valid}, 64'd0);
    check_eq({pre, "_run"}, {44'd0, run_status, run_count}, 64'd0);
    check_eq({pre, "_wr"}, imem_wr_addr | {56'd0, imem_wr_data}, 64'd0);
    check_eq({pre, "_dbg"}, {48'd0, dump_idx, reg_addr_debug, dmem_addr_debug}, 64'd0);
    check_eq({pre, "_dump_data"}, dump_data, 64'd0);
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check_eq(tag, {63'd0, done_cnt != base}, 64'd1);
  endtask

  task automatic do_load(input int len_cmd, input int gap, input bit use_pat);
    int exp_n = (len_cmd > 1024) ? 1024 : len_cmd;
    int base  = done_cnt;
    int wbase = wr_count;
    logic [7:0] d;
    cur_op   = (exp_n > 0) ? 1 : 3;
    load_len = 11'(len_cmd);
    cmd_load = 1'b1;
    @(posedge sys_clk); #1;
    cmd_load = 1'b0;
    for (int i = 0; i < exp_n; i++) begin
      int n = 0;
      d = (use_pat && i < 4) ? pat[i] : 8'($urandom_range(0, 255));
      exp_wr_q.push_back('{addr: 64'(i), data: d});
      host_valid = 1'b1;
      host_data  = d;
      @(negedge sys_clk);
      while (!host_ready && n < 50) begin
        @(negedge sys_clk);
        n++;
      end
      if (n >= 50) check_eq("load_ready_timeout", {63'd0, host_ready}, 64'd1);
      @(posedge sys_clk); #1;
      host_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge sys_clk); #1;
      end
    end
    wait_done(base, 20, "load_done");
    check_eq("load_wr_count", wr_count - wbase, exp_n);
    cur_op = 0;
  endtask

  task automatic do_run(input int rc, input int halt_at, input bit also_dump);
    int base  = done_cnt;
    int dbase = debug_cycles;
    int k = 0, n = 0;
    bit halts = (halt_at > 0 && halt_at <= rc);
    exp_run_q.push_back('{cnt: halts ? halt_at : rc, st: halts ? 4'h2 : 4'h1, base: valid_cycles});
    run_cycles = 16'(rc);
    cmd_run    = 1'b1;
    cmd_dump   = also_dump;
    @(posedge sys_clk); #1;
    cmd_run  = 1'b0;
    cmd_dump = 1'b0;
    while (done_cnt == base && n < rc + 20) begin
      if (valid) k++;
      if (halt_at > 0 && k == halt_at) status = 4'h2;
      @(posedge sys_clk); #1;
      n++;
    end
    status = 4'h1;
    check_eq("run_done", {63'd0, done_cnt != base}, 64'd1);
    check_eq("run_no_debug", debug_cycles - dbase, 64'd0);
  endtask

  task automatic do_dump();
    int base = done_cnt;
    int n = 0;
    for (int i = 0; i < 15; i++) exp_dump_q.push_back('{idx: 4'(i), data: reg_model[i]});
    cmd_dump = 1'b1;
    @(posedge sys_clk); #1;
    cmd_dump = 1'b0;
    while (done_cnt == base && n < 400) begin
      dump_ready = 1'($urandom_range(0, 1));
      @(posedge sys_clk); #1;
      n++;
    end
    dump_ready = 1'b0;
    check_eq("dump_done", {63'd0, done_cnt != base}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat[0] = 8'h30; pat[1] = 8'hF4; pat[2] = 8'h0A; pat[3] = 8'h00;
    for (int i = 0; i < 16; i++) reg_model[i] = {$urandom, $urandom};
    rst_n = 1'b0; cmd_load = 0; cmd_run = 0; cmd_dump = 0; load_len = 0; run_cycles = 0;
    host_valid = 0; host_data = 0; status = 4'h1; dump_ready = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    outs_zero("reset");
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    do_load(4, 0, 1'b1);
    do_load(6, 2, 1'b0);
    do_load(1500, 0, 1'b0);
    do_load(0, 0, 1'b0);

    do_run(20, 0, 1'b0);
    do_run(0, 0, 1'b0);
    do_run(100, 7, 1'b0);

    do_dump();

    // Reset in the middle of a load: the accepted write must vanish with reset
    load_len = 11'd4; cmd_load = 1'b1;
    @(posedge sys_clk); #1;
    cmd_load = 1'b0; host_valid = 1'b1; host_data = 8'h5A;
    @(posedge sys_clk); #1;
    check_eq("midload_wr_en", {63'd0, imem_wr_en}, 64'd1);
    host_data = 8'hA5;
    #2 rst_n = 1'b0;
    #1 outs_zero("midload_rst");
    host_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1 check_eq("midload_idle", {62'd0, busy, host_ready}, 64'd0);

    // Reset in the middle of a run
    run_cycles = 16'd100; cmd_run = 1'b1;
    @(posedge sys_clk); #1;
    cmd_run = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1 check_eq("midrun_valid", {63'd0, valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1 outs_zero("midrun_rst");
    repeat (2) @(posedge sys_clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 check_eq("midrun_idle", {62'd0, busy, valid}, 64'd0);

    // Simultaneous run and dump: run wins, no debug access
    do_run(5, 0, 1'b1);
    repeat (3) @(posedge sys_clk);
    #1 check_eq("final_queues", exp_wr_q.size() + exp_dump_q.size() + exp_run_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
